// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse position tracker.
package mouse_pkg;
  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, APPLY} state_t;

  localparam int HDR_L    = 0;
  localparam int HDR_R    = 1;
  localparam int HDR_M    = 2;
  localparam int HDR_SYNC = 3;
  localparam int HDR_XS   = 4;
  localparam int HDR_YS   = 5;
  localparam int HDR_XO   = 6;
  localparam int HDR_YO   = 7;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int TIMER_W  = 17;
endpackage

// File: rtl/mouse_axis_accum.sv
// One axis: decodes a 9-bit PS/2 delta (with overflow saturation) and returns
// the position after adding it, clamped to [0, MAX].
module mouse_axis_accum #(
  parameter int MAX = 639
) (
  input  logic [9:0] cur,
  input  logic [8:0] delta,
  input  logic       ovf,
  input  logic       invert,
  output logic [9:0] next
);
  localparam logic signed [11:0] MAX_S = 12'(MAX);
  localparam logic [9:0]         MAX_C = 10'(MAX);

  logic signed [11:0] d;
  logic signed [11:0] sum;

  always_comb begin
    if (ovf) d = delta[8] ? -12'sd256 : 12'sd255;
    else     d = {{3{delta[8]}}, delta};
    // Screen y grows downward while PS/2 +y means up, hence the invert.
    sum = $signed({2'b00, cur}) + (invert ? -d : d);
    if (sum < 0)          next = '0;
    else if (sum > MAX_S) next = MAX_C;
    else                  next = sum[9:0];
  end
endmodule

// File: rtl/mouse_position_tracker.sv
// Assembles 3-byte PS/2 movement packets into a clamped absolute cursor
// position; the published position only moves on step_strobe.
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int X_MAX          = SCREEN_W - 1,
  parameter int Y_MAX          = SCREEN_H - 1,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       step_strobe,
  output logic [9:0] mouse_x,
  output logic [9:0] mouse_y,
  output logic [2:0] buttons,
  output logic       sync_error,
  output logic [7:0] packet_count
);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]         X_RST        = 10'(X_INIT);
  localparam logic [9:0]         Y_RST        = 10'(Y_INIT);

  state_t             state;
  logic [7:0]         hdr;
  logic [7:0]         dx_b;
  logic [7:0]         dy_b;
  logic [9:0]         cur_x;
  logic [9:0]         cur_y;
  logic [9:0]         next_x;
  logic [9:0]         next_y;
  logic [TIMER_W-1:0] idle_cnt;
  logic               accept;

  assign rx_ready = (state != APPLY);
  assign accept   = rx_valid && rx_ready;

  mouse_axis_accum #(.MAX(X_MAX)) u_axis_x (
    .cur(cur_x), .delta({hdr[HDR_XS], dx_b}), .ovf(hdr[HDR_XO]),
    .invert(1'b0), .next(next_x)
  );

  mouse_axis_accum #(.MAX(Y_MAX)) u_axis_y (
    .cur(cur_y), .delta({hdr[HDR_YS], dy_b}), .ovf(hdr[HDR_YO]),
    .invert(1'b1), .next(next_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WAIT_B0;
      hdr          <= '0;
      dx_b         <= '0;
      dy_b         <= '0;
      cur_x        <= X_RST;
      cur_y        <= Y_RST;
      mouse_x      <= X_RST;
      mouse_y      <= Y_RST;
      buttons      <= '0;
      sync_error   <= 1'b0;
      packet_count <= '0;
      idle_cnt     <= '0;
    end else begin
      sync_error <= 1'b0;
      // Publishing samples cur before any APPLY update in the same cycle.
      if (step_strobe) begin
        mouse_x <= cur_x;
        mouse_y <= cur_y;
      end
      case (state)
        WAIT_B0: begin
          idle_cnt <= '0;
          if (accept) begin
            if (!rx_data[HDR_SYNC]) begin
              sync_error <= 1'b1;
            end else begin
              hdr   <= rx_data;
              state <= WAIT_B1;
            end
          end
        end
        WAIT_B1, WAIT_B2: begin
          if (accept) begin
            idle_cnt <= '0;
            if (state == WAIT_B1) begin
              dx_b  <= rx_data;
              state <= WAIT_B2;
            end else begin
              dy_b  <= rx_data;
              state <= APPLY;
            end
          end else if (idle_cnt == TIMEOUT_LAST) begin
            idle_cnt   <= '0;
            sync_error <= 1'b1;
            state      <= WAIT_B0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        APPLY: begin
          idle_cnt     <= '0;
          cur_x        <= next_x;
          cur_y        <= next_y;
          buttons      <= {hdr[HDR_M], hdr[HDR_R], hdr[HDR_L]};
          packet_count <= packet_count + 8'd1;
          state        <= WAIT_B0;
        end
        default: state <= WAIT_B0;
      endcase
    end
  end
endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed plus randomized bench for mouse_position_tracker against an
// integer-arithmetic model of cursor accumulation.
module tb_mouse_position_tracker;
  localparam int TO   = 300;
  localparam int XMAX = 639;
  localparam int YMAX = 479;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       step_strobe;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic [2:0] buttons;
  logic       sync_error;
  logic [7:0] packet_count;

  mouse_position_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .step_strobe(step_strobe), .mouse_x(mouse_x),
    .mouse_y(mouse_y), .buttons(buttons), .sync_error(sync_error),
    .packet_count(packet_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sync_seen = 0;
  int exp_sync = 0;
  int cx, cy, px, py, mb, pc;

  always @(negedge clk) if (sync_error === 1'b1) sync_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int decode(input bit [7:0] b, input bit sign, input bit ovf);
    if (ovf) return sign ? -256 : 255;
    return sign ? int'(b) - 256 : int'(b);
  endfunction

  function automatic int clamp(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  task automatic model_reset();
    cx = 320; cy = 240; px = 320; py = 240; mb = 0; pc = 0;
  endtask

  task automatic model_apply(input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2);
    cx = clamp(cx + decode(b1, b0[4], b0[6]), XMAX);
    cy = clamp(cy - decode(b2, b0[5], b0[7]), YMAX);
    mb = int'(b0[2:0]);
    pc = (pc + 1) % 256;
  endtask

  task automatic send_byte(input bit [7:0] b);
    int n;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check("rx_ready_wait", rx_ready, 1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Leaves the bench just after APPLY has completed.
  task automatic send_packet(input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    model_apply(b0, b1, b2);
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    step_strobe = 1'b1;
    @(posedge clk);
    #1 step_strobe = 1'b0;
    px = cx;
    py = cy;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    check({tag, "_x"}, mouse_x, px);
    check({tag, "_y"}, mouse_y, py);
    check({tag, "_btn"}, buttons, mb);
    check({tag, "_cnt"}, packet_count, pc);
  endtask

  task automatic pkt_step(input string tag, input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2);
    send_packet(b0, b1, b2);
    step();
    check_all(tag);
  endtask

  initial begin
    int s0, n, ox, oy;
    bit [7:0] b0, b1, b2;
    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; step_strobe = 1'b0;
    model_reset();
    #12;
    check("rst_x", mouse_x, 320);
    check("rst_y", mouse_y, 240);
    check("rst_btn", buttons, 0);
    check("rst_cnt", packet_count, 0);
    check("rst_sync", sync_error, 0);
    check("rst_ready", rx_ready, 1);
    @(negedge clk) reset = 1'b0;

    pkt_step("p1", 8'h08, 8'h0A, 8'h05);
    check("p1_x_abs", mouse_x, 330);
    check("p1_y_abs", mouse_y, 235);
    send_packet(8'h08, 8'hFF, 8'h00);
    send_packet(8'h08, 8'h2D, 8'h00);
    pkt_step("x630", 8'h08, 8'h00, 8'h00);
    check("x630_abs", mouse_x, 630);
    pkt_step("xclamp", 8'h08, 8'h20, 8'h00);
    check("xclamp_abs", mouse_x, 639);
    pkt_step("y10", 8'h08, 8'h00, 8'hE1);
    check("y10_abs", mouse_y, 10);
    pkt_step("ydown", 8'h28, 8'h00, 8'h80);
    check("ydown_abs", mouse_y, 138);
    send_packet(8'h18, 8'h00, 8'h00);
    send_packet(8'h18, 8'h00, 8'h00);
    pkt_step("x100", 8'h18, 8'hE5, 8'h00);
    check("x100_abs", mouse_x, 100);
    pkt_step("xovf", 8'h58, 8'h00, 8'h00);
    check("xovf_abs", mouse_x, 0);

    s0 = sync_seen;
    send_byte(8'h00);
    exp_sync++;
    @(negedge clk); #1;
    check("stray_sync", sync_seen - s0, 1);
    pkt_step("after_stray", 8'h09, 8'h01, 8'h00);
    check("after_stray_btn", buttons, 3'b001);
    check("after_stray_x", mouse_x, 1);

    // Strobe landing in the APPLY cycle must publish the old position.
    ox = cx; oy = cy;
    send_byte(8'h08);
    send_byte(8'h07);
    send_byte(8'hFD);
    model_apply(8'h08, 8'h07, 8'hFD);
    @(negedge clk);
    step_strobe = 1'b1;
    @(posedge clk);
    #1 step_strobe = 1'b0;
    px = ox; py = oy;
    check_all("apply_strobe");
    step();
    check_all("apply_strobe_next");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        b0 = 8'($urandom);
        b0[3] = 1'b0;
        s0 = sync_seen;
        send_byte(b0);
        exp_sync++;
        @(negedge clk); #1;
        check("rand_stray", sync_seen - s0, 1);
      end else begin
        b0 = 8'($urandom);
        b0[3] = 1'b1;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        send_packet(b0, b1, b2);
        if ($urandom_range(0, 1) == 1) step();
        check_all("rand");
      end
    end

    send_byte(8'h08);
    send_byte(8'h05);
    n = 0;
    while (sync_error !== 1'b1 && n < TO + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    exp_sync++;
    check("timeout_cycles", n, TO);
    step();
    check_all("timeout_hold");
    pkt_step("after_timeout", 8'h08, 8'h01, 8'h00);

    send_byte(8'h08);
    send_byte(8'h05);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("arst_x", mouse_x, 320);
    check("arst_y", mouse_y, 240);
    check("arst_btn", buttons, 0);
    check("arst_cnt", packet_count, 0);
    check("arst_sync", sync_error, 0);
    check("arst_ready", rx_ready, 1);
    @(negedge clk) reset = 1'b0;
    pkt_step("post_reset", 8'h08, 8'h01, 8'h00);
    check("post_reset_x", mouse_x, 321);

    @(negedge clk);
    check("sync_total", sync_seen, exp_sync);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
